dst_result_collector: RTL



---
 rtl/dst_result_collector_if.sv | 46 ++++
 rtl/dst_result_collector.sv | 106 ++++++++++
 2 files changed

// File: rtl/dst_result_collector_if.sv
// Bundle between the compressor harness and the result collector:
// 27 result columns and control in, signature and serial stream out.
interface dst_result_collector_if;
  logic dst0, dst1, dst2, dst3;
  logic dst4, dst5, dst6, dst7;
  logic dst8, dst9, dst10, dst11;
  logic dst12, dst13, dst14, dst15;
  logic dst16, dst17, dst18, dst19;
  logic dst20, dst21, dst22, dst23;
  logic dst24, dst25, dst26;
  logic misr_en;
  logic misr_clr;
  logic capture;
  logic [31:0] signature;
  logic sout;
  logic sout_valid;
  logic busy;
  logic done;
  logic drop;

  modport master (
    output dst0, dst1, dst2, dst3,
    output dst4, dst5, dst6, dst7,
    output dst8, dst9, dst10, dst11,
    output dst12, dst13, dst14, dst15,
    output dst16, dst17, dst18, dst19,
    output dst20, dst21, dst22, dst23,
    output dst24, dst25, dst26,
    output misr_en, misr_clr, capture,
    input  signature, sout, sout_valid,
    input  busy, done, drop
  );

  modport slave (
    input  dst0, dst1, dst2, dst3,
    input  dst4, dst5, dst6, dst7,
    input  dst8, dst9, dst10, dst11,
    input  dst12, dst13, dst14, dst15,
    input  dst16, dst17, dst18, dst19,
    input  dst20, dst21, dst22, dst23,
    input  dst24, dst25, dst26,
    input  misr_en, misr_clr, capture,
    output signature, sout, sout_valid,
    output busy, done, drop
  );
endinterface

// File: rtl/dst_result_collector.sv
// Folds the compressor result columns into a MISR signature and
// serializes captured result words LSB first.
module dst_result_collector #(
  parameter logic [31:0] POLY = 32'h04C11DB7,
  parameter logic [31:0] SEED = 32'h00000000
) (
  input logic clk,
  input logic rst_n,
  dst_result_collector_if.slave bus
);
  localparam int WIDTH = 27;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      sig_q, sig_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;

  assign r = {
    bus.dst26, bus.dst25, bus.dst24,
    bus.dst23, bus.dst22, bus.dst21,
    bus.dst20, bus.dst19, bus.dst18,
    bus.dst17, bus.dst16, bus.dst15,
    bus.dst14, bus.dst13, bus.dst12,
    bus.dst11, bus.dst10, bus.dst9,
    bus.dst8,  bus.dst7,  bus.dst6,
    bus.dst5,  bus.dst4,  bus.dst3,
    bus.dst2,  bus.dst1,  bus.dst0
  };

  // clr has priority over en, so both may be high together
  always_comb begin
    sig_d = sig_q;
    if (bus.misr_clr) begin
      sig_d = SEED;
    end else if (bus.misr_en) begin
      sig_d = {sig_q[30:0], 1'b0}
            ^ (sig_q[31] ? POLY : 32'h0)
            ^ {{(32-WIDTH){1'b0}}, r};
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (bus.capture) begin
          shreg_d = r;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.capture) begin
          drop_d = 1'b1;
        end
        // zero fill leaves shreg clear once the word is out
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sig_q   <= SEED;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.signature  = sig_q;
  assign bus.sout       = shreg_q[0];
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = done_q;
  assign bus.drop       = drop_q;
endmodule
